// File: rtl/gba_sound_pkg.sv
// gba_sound_pkg: shared constants and refill FSM states for the GBA DMA-sound FIFOs
package gba_sound_pkg;

    localparam int FIFO_DEPTH_LOG2 = 3;
    localparam int FIFO_DRQ_LEVEL  = 4;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        LATCH
    } fifo_state_t;

endpackage

// File: rtl/gba_sound_fifo_ram.sv
// SyncRamDual: simple dual-port RAM, port A write-only, port B registered read-only
module SyncRamDual #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] datain_a,
    input  logic                  re_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] dataout_b
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Port A write
    always_ff @(posedge clk)
        if (we_a) mem[addr_a] <= datain_a;

    // Port B registered read
    always_ff @(posedge clk)
        if (re_b) dataout_b <= mem[addr_b];

endmodule

// File: rtl/gba_sound_fifo.sv
// gba_sound_fifo: one GBA DMA-sound FIFO, 32-bit words in, one signed byte out per timer tick.
// Optional GBA_SOUND_FIFO_DEBUG_EN adds sticky overrun/underrun flags.
module gba_sound_fifo
    import gba_sound_pkg::*;
#(
    parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2,
    parameter int DRQ_LEVEL  = FIFO_DRQ_LEVEL
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [31:0]           wr_data,
    input  logic                  tick,
    output logic [7:0]            sample,
    output logic                  sample_valid,
    output logic                  dma_req,
    output logic [DEPTH_LOG2:0]   level
`ifdef GBA_SOUND_FIFO_DEBUG_EN
    ,
    output logic                  overrun,
    output logic                  underrun
`endif
);

    localparam int AW = DEPTH_LOG2;
    localparam logic [AW:0] CAP = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] DRQ = DRQ_LEVEL[AW:0];

    fifo_state_t   state, state_d;
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic [2:0]    byte_left;
    logic [31:0]   hold, ram_q;
    logic          we, re, pop;

    assign level = cnt + (AW+1)'(byte_left != 3'd0);
    assign we    = wr_en && !clear && level < CAP;
    assign pop   = tick && byte_left != 3'd0;

    SyncRamDual #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) u_ram (
        .clk       (clk),
        .we_a      (we),
        .addr_a    (wp),
        .datain_a  (wr_data),
        .re_b      (re),
        .addr_b    (rp),
        .dataout_b (ram_q)
    );

    // Refill FSM state register
    always_ff @(posedge clk)
        state <= (!reset_n || clear) ? IDLE : state_d;

    // Refill FSM: fetch the next word once the holding register runs dry
    always_comb begin
        state_d = state;
        re      = 1'b0;
        case (state)
            IDLE:    state_d = (byte_left == 3'd0 && cnt != '0) ? READ : IDLE;
            READ:    begin re = 1'b1; state_d = LATCH; end
            LATCH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pointers, word count, byte shifter and output pulses
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            wp           <= '0;
            rp           <= '0;
            cnt          <= '0;
            byte_left    <= 3'd0;
            hold         <= 32'd0;
            sample       <= 8'd0;
            sample_valid <= 1'b0;
            dma_req      <= 1'b0;
        end else begin
            wp           <= wp + AW'(we);
            rp           <= rp + AW'(re);
            cnt          <= cnt + (AW+1)'(we) - (AW+1)'(re);
            sample_valid <= pop;
            dma_req      <= pop && byte_left == 3'd1 && cnt <= DRQ;
            if (pop) begin
                sample    <= hold[7:0];
                hold      <= hold >> 8;
                byte_left <= byte_left - 3'd1;
            end else if (state == LATCH) begin
                hold      <= ram_q;
                byte_left <= 3'd4;
            end
        end
    end

`ifdef GBA_SOUND_FIFO_DEBUG_EN
    // Sticky flags for dropped writes and lost ticks
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            overrun  <= overrun | (wr_en && level >= CAP);
            underrun <= underrun | (tick && byte_left == 3'd0);
        end
    end
`endif

endmodule

// File: tb/tb_gba_sound_fifo.sv
// tb_gba_sound_fifo: table vectors, directed corner sequences and random traffic against a queue model
module tb_gba_sound_fifo;

    logic        clk = 1'b0, reset_n = 1'b0, clear = 1'b0, wr_en = 1'b0, tick = 1'b0;
    logic [31:0] wr_data = 32'd0;
    logic [7:0]  sample;
    logic        sample_valid, dma_req;
    logic [3:0]  level;
`ifdef GBA_SOUND_FIFO_DEBUG_EN
    logic        overrun, underrun;
`endif

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    gba_sound_fifo dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .tick         (tick),
        .sample       (sample),
        .sample_valid (sample_valid),
        .dma_req      (dma_req),
        .level        (level)
`ifdef GBA_SOUND_FIFO_DEBUG_EN
        ,
        .overrun      (overrun),
        .underrun     (underrun)
`endif
    );

    // Behavioural model: queued RAM words, bytes of the word being played, and a word in transit
    logic [31:0] m_words[$];
    logic [7:0]  m_bytes[$];
    logic [7:0]  got[$];
    int          m_ph = 0;
    logic [31:0] m_xfer = 32'd0;
    logic [7:0]  m_sample = 8'd0;
    logic        m_valid = 1'b0, m_dma = 1'b0, m_ovr = 1'b0, m_und = 1'b0;

    function automatic int m_level();
        return m_words.size() + (m_bytes.size() != 0 ? 1 : 0);
    endfunction

    task automatic model_step();
        int   lvl = m_level();
        int   cnt = m_words.size();
        logic empty = (m_bytes.size() == 0);
        if (!reset_n || clear) begin
            m_words.delete();
            m_bytes.delete();
            m_ph = 0;
            m_sample = 8'd0;
            m_valid = 1'b0;
            m_dma = 1'b0;
            m_ovr = 1'b0;
            m_und = 1'b0;
        end else begin
            m_valid = 1'b0;
            m_dma = 1'b0;
            if (tick && !empty) begin
                m_sample = m_bytes.pop_front();
                m_valid = 1'b1;
                m_dma = (m_bytes.size() == 0) && (cnt <= 4);
            end else if (tick) m_und = 1'b1;
            if (m_ph == 2) begin
                for (int i = 0; i < 4; i++) m_bytes.push_back(m_xfer[8*i +: 8]);
                m_ph = 0;
            end else if (m_ph == 1) begin
                m_xfer = m_words.pop_front();
                m_ph = 2;
            end else if (empty && cnt > 0) m_ph = 1;
            if (wr_en) begin
                if (lvl < 8) m_words.push_back(wr_data);
                else m_ovr = 1'b1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("sample", {24'd0, sample}, {24'd0, m_sample});
        chk("sample_valid", {31'd0, sample_valid}, {31'd0, m_valid});
        chk("dma_req", {31'd0, dma_req}, {31'd0, m_dma});
        chk("level", {28'd0, level}, m_level());
`ifdef GBA_SOUND_FIFO_DEBUG_EN
        chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        chk("underrun", {31'd0, underrun}, {31'd0, m_und});
`endif
        if (sample_valid) got.push_back(sample);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic put(input logic [31:0] w);
        wr_en = 1'b1;
        wr_data = w;
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] d;
        logic        tk;
        logic [7:0]  s;
        logic        v;
        logic        dq;
        logic [3:0]  lv;
    } vec_t;

    vec_t        tbl[9];
    logic [31:0] words[32];

    initial begin
        tbl[0] = '{1'b1, 32'h04030201, 1'b0, 8'h00, 1'b0, 1'b0, 4'd1};
        tbl[1] = '{1'b0, 32'h0,        1'b0, 8'h00, 1'b0, 1'b0, 4'd1};
        tbl[2] = '{1'b0, 32'h0,        1'b0, 8'h00, 1'b0, 1'b0, 4'd0};
        tbl[3] = '{1'b0, 32'h0,        1'b0, 8'h00, 1'b0, 1'b0, 4'd1};
        tbl[4] = '{1'b0, 32'h0,        1'b1, 8'h01, 1'b1, 1'b0, 4'd1};
        tbl[5] = '{1'b0, 32'h0,        1'b1, 8'h02, 1'b1, 1'b0, 4'd1};
        tbl[6] = '{1'b0, 32'h0,        1'b1, 8'h03, 1'b1, 1'b0, 4'd1};
        tbl[7] = '{1'b0, 32'h0,        1'b1, 8'h04, 1'b1, 1'b1, 4'd0};
        tbl[8] = '{1'b0, 32'h0,        1'b1, 8'h04, 1'b0, 1'b0, 4'd0};

        idle(2);
        chk("rst_sample", {24'd0, sample}, 32'd0);
        chk("rst_valid", {31'd0, sample_valid}, 32'd0);
        chk("rst_dma", {31'd0, dma_req}, 32'd0);
        chk("rst_level", {28'd0, level}, 32'd0);
        reset_n = 1'b1;
        idle(2);

        for (int i = 0; i < 9; i++) begin
            wr_en = tbl[i].wr;
            wr_data = tbl[i].d;
            tick = tbl[i].tk;
            cycle();
            chk("t1_sample", {24'd0, sample}, {24'd0, tbl[i].s});
            chk("t1_valid", {31'd0, sample_valid}, {31'd0, tbl[i].v});
            chk("t1_dma", {31'd0, dma_req}, {31'd0, tbl[i].dq});
            chk("t1_level", {28'd0, level}, {28'd0, tbl[i].lv});
        end
        wr_en = 1'b0;
        tick = 1'b0;
`ifdef GBA_SOUND_FIFO_DEBUG_EN
        chk("t1_underrun", {31'd0, underrun}, 32'd1);
`endif

        pulse_clear();
        got.delete();
        for (int k = 0; k < 9; k++) begin
            words[k] = $urandom;
            put(words[k]);
        end
        idle(4);
        chk("t2_level", {28'd0, level}, 32'd8);
`ifdef GBA_SOUND_FIFO_DEBUG_EN
        chk("t2_overrun", {31'd0, overrun}, 32'd1);
`endif
        repeat (32) begin
            tick = 1'b1;
            cycle();
            tick = 1'b0;
            idle(3);
        end
        chk("t2_count", got.size(), 32'd32);
        for (int k = 0; k < 32 && k < got.size(); k++)
            chk("t2_byte", {24'd0, got[k]}, {24'd0, words[k/4][8*(k%4) +: 8]});

        pulse_clear();
        for (int k = 0; k < 8; k++) put($urandom);
        idle(4);
        for (int t = 1; t <= 16; t++) begin
            tick = 1'b1;
            cycle();
            tick = 1'b0;
            chk("t3_dma", {31'd0, dma_req}, {31'd0, t == 16});
            idle(3);
        end

        pulse_clear();
        for (int k = 0; k < 5; k++) put($urandom);
        idle(4);
        chk("t4_level5", {28'd0, level}, 32'd5);
        tick = 1'b1;
        idle(2);
        tick = 1'b0;
        clear = 1'b1;
        wr_en = 1'b1;
        wr_data = 32'hDEADBEEF;
        cycle();
        clear = 1'b0;
        wr_en = 1'b0;
        chk("t4_level0", {28'd0, level}, 32'd0);
        chk("t4_sample0", {24'd0, sample}, 32'd0);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        chk("t4_novalid", {31'd0, sample_valid}, 32'd0);
        idle(4);
        chk("t4_dropped", {28'd0, level}, 32'd0);

        pulse_clear();
        for (int k = 0; k < 27; k++) words[k] = 32'h01010101 * (k + 1) + 32'h00030201;
        for (int k = 0; k < 7; k++) put(words[k]);
        idle(4);
        chk("t5_level7", {28'd0, level}, 32'd7);
        got.delete();
        for (int k = 0; k < 20 * 16; k++) begin
            tick = (k % 4 == 0);
            wr_en = (k % 16 == 0);
            wr_data = words[7 + k / 16];
            cycle();
        end
        wr_en = 1'b0;
        for (int n = 0; n < 200; n++) begin
            tick = (n % 4 == 0);
            cycle();
        end
        tick = 1'b0;
        chk("t5_count", got.size(), 32'd108);
        for (int k = 0; k < 108 && k < got.size(); k++)
            chk("t5_byte", {24'd0, got[k]}, {24'd0, words[k/4][8*(k%4) +: 8]});

        pulse_clear();
        put(32'hA1B2C3D4);
        idle(2);
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        chk("t6_sample", {24'd0, sample}, 32'd0);
        chk("t6_valid", {31'd0, sample_valid}, 32'd0);
        chk("t6_dma", {31'd0, dma_req}, 32'd0);
        chk("t6_level", {28'd0, level}, 32'd0);
        got.delete();
        put(32'h88776655);
        idle(3);
        tick = 1'b1;
        idle(4);
        tick = 1'b0;
        chk("t6_count", got.size(), 32'd4);
        for (int k = 0; k < 4 && k < got.size(); k++)
            chk("t6_byte", {24'd0, got[k]}, 32'h55 + 32'h11 * k);

        pulse_clear();
        for (int n = 0; n < 3000; n++) begin
            wr_en = 1'($urandom_range(0, 1));
            wr_data = $urandom;
            tick = ($urandom_range(0, 3) == 0);
            clear = ($urandom_range(0, 99) == 0);
            cycle();
        end
        wr_en = 1'b0;
        tick = 1'b0;
        clear = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
